// File: rtl/ps2_rx_pkg.sv
// Shared PS/2 receiver definitions: frame layout, read-word fields, FSM states
// and the CPU-visible register address.
package ps2_rx_pkg;

    localparam int          PS2_FRAME_LEN = 11;
    localparam int          PS2_BIT_VALID = 15;
    localparam int          PS2_BIT_OVF   = 14;
    localparam int          PS2_BYTE_MSB  = 7;
    localparam int          PS2_BYTE_LSB  = 0;
    localparam logic [15:0] PS2_REG       = 16'hF000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_ones(input logic [8:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous DEPTH x 8 FIFO for received scan codes; pushes into a full
// FIFO and pops from an empty FIFO are ignored.
module ps2_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_empty,
    output logic [7:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic        w_push_ok, w_pop_ok;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and filters the pins, deframes
// 11-bit frames, queues good bytes and exposes the queue head as a read word.
module ps2_rx
    import ps2_rx_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 25000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        ren,
    output logic [15:0] data_out,
    output logic        parity_err
);
    localparam int          FW   = $clog2(FILTER_LEN + 1);
    localparam int          TW   = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic [1:0]    r_clk_s, r_dat_s;
    logic          r_filt, r_filt_d;
    logic [FW-1:0] r_fcnt;
    logic          w_dat, w_fall;

    ps2_state_e    r_state, w_state_n;
    logic [2:0]    r_bcnt, w_bcnt_n;
    logic [7:0]    r_shift, w_shift_n;
    logic          r_par, w_par_n;
    logic [TW-1:0] r_tcnt, w_tcnt_n;
    logic          r_push, w_push_n;
    logic          r_perr, w_perr_n;
    logic          r_ovf;

    logic          w_full, w_empty, w_pop;
    logic [7:0]    w_head;
    logic [15:0]   w_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s <= 2'b11;
            r_dat_s <= 2'b11;
        end else begin
            r_clk_s <= {r_clk_s[0], ps2_clk};
            r_dat_s <= {r_dat_s[0], ps2_data};
        end
    end

    // Level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (r_clk_s[1] == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FMAX) begin
                r_filt <= r_clk_s[1];
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign w_fall = r_filt_d && !r_filt;
    assign w_dat  = r_dat_s[1];

    always_comb begin
        w_state_n = r_state;
        w_bcnt_n  = r_bcnt;
        w_shift_n = r_shift;
        w_par_n   = r_par;
        w_tcnt_n  = '0;
        w_push_n  = 1'b0;
        w_perr_n  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall && !w_dat) begin
                    w_state_n = ST_DATA;
                    w_bcnt_n  = '0;
                end
            end
            ST_DATA: begin
                if (w_fall) begin
                    w_shift_n = {w_dat, r_shift[7:1]};
                    w_bcnt_n  = r_bcnt + 1'b1;
                    if (r_bcnt == 3'd7) w_state_n = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (w_fall) begin
                    w_par_n   = w_dat;
                    w_state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_fall) begin
                    w_state_n = ST_IDLE;
                    if (w_dat && odd_ones({r_shift, r_par})) w_push_n = 1'b1;
                    else                                      w_perr_n = 1'b1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
        if (r_state != ST_IDLE && !w_fall) begin
            if (r_tcnt == TMAX) begin
                w_state_n = ST_IDLE;
                w_tcnt_n  = '0;
            end else begin
                w_tcnt_n = r_tcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tcnt  <= '0;
            r_push  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_bcnt  <= w_bcnt_n;
            r_shift <= w_shift_n;
            r_par   <= w_par_n;
            r_tcnt  <= w_tcnt_n;
            r_push  <= w_push_n;
            r_perr  <= w_perr_n;
        end
    end

    // r_shift is still the completed byte while r_push is high: the next
    // frame cannot shift until many cycles later.
    assign w_pop = ren && !w_empty;

    ps2_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_push),
        .i_din   (r_shift),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_comb begin
        w_word                             = '0;
        w_word[PS2_BIT_VALID]              = !w_empty;
        w_word[PS2_BIT_OVF]                = r_ovf;
        if (!w_empty) w_word[PS2_BYTE_MSB:PS2_BYTE_LSB] = w_head;
    end

    // A drop on the same cycle as a read stays flagged for the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf    <= 1'b0;
            data_out <= '0;
        end else begin
            if (r_push && w_full) r_ovf <= 1'b1;
            else if (ren)         r_ovf <= 1'b0;
            if (ren) data_out <= w_word;
        end
    end

    assign parity_err = r_perr;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: table-driven frames plus hand-written
// corner sequences, scored against a byte-queue model of the receiver.
module tb_ps2_rx;
    localparam int DEPTH      = 16;
    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 2000;
    localparam int H          = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        ren = 1'b0;
    logic [15:0] data_out;
    logic        parity_err;

    int n_vec = 0;
    int n_err = 0;
    int perr_cnt = 0;

    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;
    logic [15:0] last_exp = 16'h0000;

    typedef struct {
        logic [7:0] b;
        bit         flip;
        bit         badstop;
        int         exp_perr;
    } vec_t;
    vec_t vecs[6];

    ps2_rx #(.DEPTH(DEPTH), .FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ren        (ren),
        .data_out   (data_out),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (parity_err) perr_cnt++;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input bit flip, input bit badstop);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = (~^b) ^ flip;
        f[10]  = ~badstop;
        return f;
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = bits[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk) ps2_data = 1'b1;
        repeat (2*H) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit flip, input bit badstop);
        send_bits(frame(b, flip, badstop), 11);
        if (!flip && !badstop) begin
            if (m_q.size() < DEPTH) m_q.push_back(b);
            else                    m_ovf = 1'b1;
        end
    endtask

    task automatic do_read(input string name);
        logic [15:0] exp;
        @(negedge clk) ren = 1'b1;
        @(negedge clk) ren = 1'b0;
        if (m_q.size() > 0) exp = {1'b1, m_ovf, 6'b0, m_q.pop_front()};
        else                exp = {1'b0, m_ovf, 14'b0};
        m_ovf    = 1'b0;
        last_exp = exp;
        chk(name, data_out, exp);
    endtask

    initial begin
        int p0;
        vecs[0] = '{8'h1C, 1'b0, 1'b0, 0};
        vecs[1] = '{8'h1C, 1'b1, 1'b0, 1};
        vecs[2] = '{8'hFF, 1'b0, 1'b0, 0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 0};
        vecs[4] = '{8'hA5, 1'b0, 1'b1, 1};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1};

        repeat (3) @(negedge clk);
        chk("reset data_out", data_out, 16'h0000);
        chk("reset parity_err", {15'b0, parity_err}, 16'h0000);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            p0 = perr_cnt;
            send(vecs[i].b, vecs[i].flip, vecs[i].badstop);
            chk($sformatf("vec%0d parity_err pulses", i), 16'(perr_cnt - p0), 16'(vecs[i].exp_perr));
            do_read($sformatf("vec%0d read", i));
            repeat (5) @(negedge clk);
            chk($sformatf("vec%0d hold", i), data_out, last_exp);
        end
        do_read("empty read after table");

        for (int i = 1; i <= DEPTH + 1; i++) send(8'(i), 1'b0, 1'b0);
        for (int i = 0; i <= DEPTH + 1; i++) do_read($sformatf("overflow read %0d", i));

        p0 = perr_cnt;
        send_bits(frame(8'h3C, 1'b0, 1'b0), 5);
        repeat (TIMEOUT + 10) @(negedge clk);
        send(8'hF0, 1'b0, 1'b0);
        chk("timeout no parity_err", 16'(perr_cnt - p0), 16'h0000);
        do_read("timeout read F0");
        do_read("timeout read empty");

        @(negedge clk) ps2_data = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
        ps2_data = 1'b1;
        repeat (2*H) @(negedge clk);
        do_read("glitch no push");
        send(8'h33, 1'b0, 1'b0);
        do_read("glitch then frame");

        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h44, 1'b0, 1'b0);
        do_read("pre-reset read");
        send_bits(frame(8'h77, 1'b0, 1'b0), 4);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async reset data_out", data_out, 16'h0000);
        m_q.delete();
        m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        do_read("post-reset empty");
        send(8'h5A, 1'b0, 1'b0);
        do_read("post-reset 5A");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
